// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared constants and boot loader state encoding for MCPU
package mcpu_pkg;
  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 8;
  localparam int BOOT_WORD_BYTES = 2;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_COUNT,
    ST_GET_HI,
    ST_GET_LO,
    ST_WRITE,
    ST_GET_CSUM,
    ST_DONE,
    ST_ERROR
  } boot_state_t;
endpackage

// File: rtl/boot_byte_assembler.sv
// boot_byte_assembler: packs hi/lo stream bytes into a RAM word and keeps the frame XOR checksum
module boot_byte_assembler
  import mcpu_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   in_data,
  input  logic                         load_acc,
  input  logic                         take_hi,
  input  logic                         take_lo,
  output logic [8*BOOT_WORD_BYTES-1:0] word,
  output logic [7:0]                   acc
);
  logic [7:0] hi;
  // COUNT seeds the checksum; every data byte is folded in as it is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      word <= '0;
      acc  <= '0;
    end else begin
      if (load_acc) acc <= in_data;
      if (take_hi) begin
        hi  <= in_data;
        acc <= acc ^ in_data;
      end
      if (take_lo) begin
        word <= {hi, in_data};
        acc  <= acc ^ in_data;
      end
    end
  end
endmodule

// File: rtl/mcpu_boot_loader.sv
// mcpu_boot_loader: framed byte-stream program loader that writes MCPU RAM and gates CPU reset
module mcpu_boot_loader #(
  parameter int                    WORD_SIZE = 16,
  parameter int                    ADDR_SIZE = 8,
  parameter logic [ADDR_SIZE-1:0]  BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 start,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error
);
  import mcpu_pkg::*;
  boot_state_t state, next_state;
  logic [7:0] n, cnt, acc;
  logic [ADDR_SIZE-1:0] ptr;
  logic [8*BOOT_WORD_BYTES-1:0] word;
  logic xfer, ready_d, we_d, done_d, error_d, cpu_reset_d;
  assign xfer = in_valid & in_ready;
  boot_byte_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .load_acc (state == ST_GET_COUNT && xfer),
    .take_hi  (state == ST_GET_HI && xfer),
    .take_lo  (state == ST_GET_LO && xfer),
    .word     (word),
    .acc      (acc)
  );
  assign mem_wdata = WORD_SIZE'(word);
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end
  // next-state logic; a stalled stream simply holds the current state
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      next_state = ST_GET_COUNT;
      ST_GET_COUNT: if (xfer) next_state = (in_data == 8'd0) ? ST_GET_CSUM : ST_GET_HI;
      ST_GET_HI:    if (xfer) next_state = ST_GET_LO;
      ST_GET_LO:    if (xfer) next_state = ST_WRITE;
      ST_WRITE:     next_state = (cnt + 8'd1 == n) ? ST_GET_CSUM : ST_GET_HI;
      ST_GET_CSUM:  if (xfer) next_state = (in_data == acc) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR:     if (start) next_state = ST_GET_COUNT;
      default:      next_state = ST_IDLE;
    endcase
  end
  // output decode from the upcoming state so every output comes straight from a flop
  always_comb begin
    ready_d     = next_state inside {ST_GET_COUNT, ST_GET_HI, ST_GET_LO, ST_GET_CSUM};
    we_d        = next_state == ST_WRITE;
    done_d      = next_state == ST_DONE;
    error_d     = next_state == ST_ERROR;
    cpu_reset_d = next_state != ST_DONE;
  end
  // registered control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      in_ready  <= ready_d;
      mem_we    <= we_d;
      done      <= done_d;
      error     <= error_d;
      cpu_reset <= cpu_reset_d;
    end
  end
  // word count, RAM pointer and the address presented during WRITE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n        <= '0;
      cnt      <= '0;
      ptr      <= '0;
      mem_addr <= '0;
    end else begin
      if (state == ST_GET_COUNT && xfer) begin
        n   <= in_data;
        cnt <= '0;
        ptr <= BASE_ADDR;
      end
      if (state == ST_GET_LO && xfer) mem_addr <= ptr;
      if (state == ST_WRITE) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: doc/mcpu_boot_loader.md
Name: mcpu_boot_loader

Overview:
Byte-serial program loader sitting directly upstream of MCPU's instruction/data RAM (raminst). It receives a framed program image over a valid/ready byte stream and writes 16-bit instruction words into RAM through a write port. It holds MCPU in reset until the image is fully written and its checksum verifies. It replaces hierarchical memory preloading with a synthesizable path.

Parameters:
WORD_SIZE, 16, RAM word / instruction width; fixed at 2 bytes per word.
ADDR_SIZE, 8, RAM address width (256 words).
BASE_ADDR, 0, first RAM address written; addresses wrap modulo 2^ADDR_SIZE.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts a byte this cycle.
start  input  1  one-cycle pulse; restarts loading from DONE or ERROR.
mem_we  output  1  RAM write strobe, one cycle per word.
mem_addr  output  ADDR_SIZE  RAM write address.
mem_wdata  output  WORD_SIZE  RAM write data.
cpu_reset  output  1  active-high reset to MCPU; 1 until a successful load.
done  output  1  load completed and checksum matched.
error  output  1  checksum mismatch.

Behaviour:
- Frame format: COUNT byte N (number of words, 0..255), then N words (high byte first, then low byte), then CSUM byte. CSUM is the XOR of COUNT and all data bytes.
- A byte transfers on a rising clk edge with in_valid=1 and in_ready=1. in_ready is a registered output.
- States: IDLE, GET_COUNT, GET_HI, GET_LO, WRITE, GET_CSUM, DONE, ERROR.
- Reset (reset=0), asynchronous: state=IDLE, cpu_reset=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0. The internal word counter, address pointer and XOR accumulator are also cleared.
- IDLE lasts one cycle, then moves unconditionally to GET_COUNT.
- GET_COUNT: on transfer, latch N and set acc=in_data. If N=0, go to GET_CSUM; otherwise go to GET_HI with ptr=BASE_ADDR.
- GET_HI: on transfer, latch the high byte, XOR it into acc, go to GET_LO.
- GET_LO: on transfer, latch the low byte, XOR it into acc, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=ptr, mem_wdata={hi,lo}.
  - Then ptr increments with wrap (0xFF to 0x00) and the word count increments.
  - If the count reaches N, go to GET_CSUM; otherwise go to GET_HI.
- GET_CSUM: on transfer, compare in_data with acc. Match: go to DONE. Mismatch: go to ERROR.
- DONE: done=1, cpu_reset=0, in_ready=0.
- ERROR: error=1, cpu_reset=1, in_ready=0.
- start in DONE or ERROR: next cycle state=GET_COUNT, cpu_reset=1, done=0, error=0. start is ignored in all other states.
- in_ready is 1 only in GET_COUNT, GET_HI, GET_LO and GET_CSUM. It is 0 in IDLE, WRITE, DONE and ERROR. Maximum throughput is 1 word per 3 cycles.
- in_valid=0 stalls the current state indefinitely; no timeout.
- mem_we is 0 outside WRITE. mem_addr and mem_wdata hold their last values.
- Reset mid-frame aborts immediately. No partial-frame state survives, and RAM words already written are not undone.
- All outputs are registered except none; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package mcpu_pkg holds:
  - state encoding constants;
  - BOOT_WORD_BYTES = 2;
  - the existing WORD_SIZE and ADDR_SIZE constants.
- One sub-module, boot_byte_assembler, is natural. It collects hi/lo bytes into a word and maintains the XOR accumulator. The FSM stays in mcpu_boot_loader.

Test Plan:
1. Reset release -> first cycle IDLE with in_ready=0, next cycle in_ready=1; cpu_reset=1, done=0, error=0 throughout.
2. Frame 02,A1,B2,03,04,16 with BASE_ADDR=0 -> mem[0]=A1B2, mem[1]=0304, one mem_we pulse each; then done=1, cpu_reset=0.
3. Same frame with CSUM=17 -> both words written; error=1, done=0, cpu_reset stays 1; a start pulse returns in_ready=1 with error=0.
4. BASE_ADDR=FE, frame 03,00,01,00,02,00,03,03 -> writes at FE=0001, FF=0002, 00=0003 (address wrap); done=1.
5. Frame 00,00 -> no mem_we; done=1. In a separate run, deassert in_valid for 10 cycles between the hi and lo bytes -> no write until the lo byte arrives, same data.
6. Assert reset after the hi byte of word 1 -> immediate IDLE state values; a full valid frame afterwards loads correctly.
